step_controller: RTL and testbench

STEP_CONTROLLER -- requirements
Module: step_controller

---
 rtl/step_controller.sv | 110 +++++++++++
 tb/tb_step_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_controller.sv
// rtl/step_controller.sv - rotor step sequencing and key presentation for the rotor chain
module step_controller #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [25:0] key_in,
  output logic        key_ready,
  input  logic        notch_r,
  input  logic        notch_m,
  output logic        rotate_r,
  output logic        rotate_m,
  output logic        rotate_l,
  output logic [25:0] char_out,
  output logic        char_valid,
  input  logic        char_ack,
  output logic        bad_key,
  output logic [15:0] key_count
);

  typedef enum logic [1:0] {IDLE, STEP, SETTLE, PRESENT} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t      state_q;
  logic [3:0]  settle_q;
  logic        rotate_r_q;
  logic        rotate_m_q;
  logic        rotate_l_q;
  logic        key_ready_q;
  logic        char_valid_q;
  logic        bad_key_q;
  logic [25:0] char_out_q;
  logic [15:0] key_count_q;
  logic [15:0] key_count_d;
  logic        key_onehot;

  assign key_onehot  = (key_in != 26'd0) && ((key_in & (key_in - 26'd1)) == 26'd0);
  assign key_count_d = key_count_q + 16'd1;

  // rotate_m_q/rotate_l_q double as the captured step_m/step_l for the STEP cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_q     <= 4'd0;
      rotate_r_q   <= 1'b0;
      rotate_m_q   <= 1'b0;
      rotate_l_q   <= 1'b0;
      key_ready_q  <= 1'b1;
      char_valid_q <= 1'b0;
      bad_key_q    <= 1'b0;
      char_out_q   <= 26'd0;
      key_count_q  <= 16'd0;
    end else begin
      rotate_r_q <= 1'b0;
      rotate_m_q <= 1'b0;
      rotate_l_q <= 1'b0;
      bad_key_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            if (key_onehot) begin
              char_out_q  <= key_in;
              key_count_q <= key_count_d;
              rotate_r_q  <= 1'b1;
              rotate_m_q  <= notch_r | notch_m;
              rotate_l_q  <= notch_m;
              key_ready_q <= 1'b0;
              state_q     <= STEP;
            end else begin
              bad_key_q <= 1'b1;
            end
          end
        end
        STEP: begin
          settle_q <= SETTLE_LOAD;
          state_q  <= SETTLE;
        end
        // Exit on zero so char_valid rises 1 + SETTLE_CYCLES + 1 cycles after accept.
        SETTLE: begin
          if (settle_q == 4'd0) begin
            char_valid_q <= 1'b1;
            state_q      <= PRESENT;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        PRESENT: begin
          if (char_ack) begin
            char_valid_q <= 1'b0;
            key_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ready  = key_ready_q;
  assign rotate_r   = rotate_r_q;
  assign rotate_m   = rotate_m_q;
  assign rotate_l   = rotate_l_q;
  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign bad_key    = bad_key_q;
  assign key_count  = key_count_q;

endmodule

// File: tb/tb_step_controller.sv
// tb/tb_step_controller.sv - randomized self-checking bench for step_controller
module tb_step_controller;

  localparam int S   = 2;
  localparam int LAT = S + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [25:0] key_in = 26'd0;
  logic        notch_r = 1'b0;
  logic        notch_m = 1'b0;
  logic        char_ack = 1'b0;
  logic        key_ready;
  logic        rotate_r;
  logic        rotate_m;
  logic        rotate_l;
  logic [25:0] char_out;
  logic        char_valid;
  logic        bad_key;
  logic [15:0] key_count;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 clock = ~clock;

  step_controller #(.SETTLE_CYCLES(S)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .notch_r(notch_r), .notch_m(notch_m),
    .rotate_r(rotate_r), .rotate_m(rotate_m), .rotate_l(rotate_l),
    .char_out(char_out), .char_valid(char_valid), .char_ack(char_ack),
    .bad_key(bad_key), .key_count(key_count)
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic offer(input logic [25:0] k, input logic nr, input logic nm);
    key_valid = 1'b1;
    key_in    = k;
    notch_r   = nr;
    notch_m   = nm;
  endtask

  task automatic complete();
    key_valid = 1'b0;
    repeat (LAT) tick();
    char_ack = 1'b1;
    tick();
    char_ack = 1'b0;
  endtask

  function automatic logic [25:0] rand_onehot();
    logic [25:0] one = 26'd1;
    return one << $urandom_range(0, 25);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({rotate_r, rotate_m, rotate_l, char_valid, bad_key} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {rotate_r, rotate_m, rotate_l, char_valid, bad_key});
    end
    total++;
    if (char_out !== 26'd0) begin bad++; $display("FAIL reset_char_out got=%h want=0", char_out); end
    total++;
    if (key_count !== 16'd0) begin bad++; $display("FAIL reset_key_count got=%h want=0", key_count); end
    reset = 1'b0;
    exp_count = 16'd0;
    tick();
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b want=1", key_ready); end
  endtask

  task automatic test_basic();
    offer(26'h0000001, 1'b0, 1'b0);
    tick();
    key_valid = 1'b0;
    exp_count++;
    total++;
    if ({rotate_r, rotate_m, rotate_l} !== 3'b100) begin
      bad++; $display("FAIL basic_rotate got=%b want=100", {rotate_r, rotate_m, rotate_l});
    end
    total++;
    if (key_count !== exp_count) begin bad++; $display("FAIL basic_count got=%h want=%h", key_count, exp_count); end
    for (int c = 1; c <= LAT; c++) begin
      tick();
      total++;
      if ({rotate_r, rotate_m, rotate_l, char_valid} !== {3'b000, 1'(c == LAT)}) begin
        bad++; $display("FAIL basic_latency c=%0d got=%b want=%b", c,
                        {rotate_r, rotate_m, rotate_l, char_valid}, {3'b000, 1'(c == LAT)});
      end
    end
    total++;
    if (char_out !== 26'h0000001) begin bad++; $display("FAIL basic_char_out got=%h want=1", char_out); end
    char_ack = 1'b1;
    tick();
    char_ack = 1'b0;
    total++;
    if ({char_valid, key_ready} !== 2'b01) begin
      bad++; $display("FAIL basic_ack got=%b want=01", {char_valid, key_ready});
    end
  endtask

  task automatic test_double_step();
    offer(26'h0000008, 1'b1, 1'b0);
    tick();
    exp_count++;
    total++;
    if ({rotate_r, rotate_m, rotate_l} !== 3'b110) begin
      bad++; $display("FAIL dstep_first got=%b want=110", {rotate_r, rotate_m, rotate_l});
    end
    complete();
    offer(26'h0000080, 1'b0, 1'b1);
    tick();
    exp_count++;
    total++;
    if ({rotate_r, rotate_m, rotate_l} !== 3'b111) begin
      bad++; $display("FAIL dstep_second got=%b want=111", {rotate_r, rotate_m, rotate_l});
    end
    complete();
    total++;
    if (key_count !== exp_count) begin bad++; $display("FAIL dstep_count got=%h want=%h", key_count, exp_count); end
  endtask

  task automatic test_bad_key();
    logic [25:0] pats [2];
    pats[0] = 26'h0000003;
    pats[1] = 26'h0000000;
    for (int i = 0; i < 2; i++) begin
      offer(pats[i], 1'b1, 1'b1);
      tick();
      total++;
      if ({bad_key, key_ready, rotate_r, rotate_m, rotate_l} !== 5'b11000 || key_count !== exp_count) begin
        bad++; $display("FAIL bad_key_offer%0d got=%b cnt=%h want=11000 cnt=%h", i,
                        {bad_key, key_ready, rotate_r, rotate_m, rotate_l}, key_count, exp_count);
      end
    end
    key_valid = 1'b0;
    tick();
    total++;
    if ({bad_key, key_ready} !== 2'b01) begin bad++; $display("FAIL bad_key_end got=%b want=01", {bad_key, key_ready}); end
  endtask

  task automatic test_hold();
    logic [25:0] k = rand_onehot();
    offer(k, 1'b0, 1'b0);
    tick();
    exp_count++;
    key_valid = 1'b0;
    repeat (LAT) tick();
    for (int i = 0; i < 10; i++) begin
      offer(rand_onehot(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      total++;
      if ({char_valid, key_ready, rotate_r, rotate_m, rotate_l, bad_key} !== 6'b100000 || char_out !== k) begin
        bad++; $display("FAIL hold_cycle%0d got=%b out=%h want=100000 out=%h", i,
                        {char_valid, key_ready, rotate_r, rotate_m, rotate_l, bad_key}, char_out, k);
      end
    end
    char_ack = 1'b1;
    tick();
    char_ack  = 1'b0;
    key_valid = 1'b0;
    total++;
    if ({char_valid, key_ready, bad_key} !== 3'b010 || key_count !== exp_count) begin
      bad++; $display("FAIL hold_release got=%b cnt=%h want=010 cnt=%h",
                      {char_valid, key_ready, bad_key}, key_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] k = rand_onehot();
    offer(k, 1'b1, 1'b1);
    tick();
    reset = 1'b1;
    key_valid = 1'b0;
    #1;
    total++;
    if ({rotate_r, rotate_m, rotate_l} !== 3'b000) begin
      bad++; $display("FAIL rst_step_trunc got=%b want=000", {rotate_r, rotate_m, rotate_l});
    end
    @(negedge clock);
    reset = 1'b0;
    exp_count = 16'd0;
    tick();
    total++;
    if ({rotate_r, rotate_m, rotate_l} !== 3'b000 || key_count !== 16'd0) begin
      bad++; $display("FAIL rst_step_after got=%b cnt=%h want=000 cnt=0", {rotate_r, rotate_m, rotate_l}, key_count);
    end
    offer(k, 1'b0, 1'b0);
    tick();
    key_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ({rotate_r, rotate_m, rotate_l, char_valid, bad_key} !== 5'b0 || char_out !== 26'd0 || key_count !== 16'd0) begin
      bad++; $display("FAIL rst_settle got=%b out=%h cnt=%h want=00000 out=0 cnt=0",
                      {rotate_r, rotate_m, rotate_l, char_valid, bad_key}, char_out, key_count);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_count = 16'd0;
    #1;
    total++;
    if (key_ready !== 1'b1) begin bad++; $display("FAIL rst_settle_ready got=%b want=1", key_ready); end
    @(negedge clock);
    k = rand_onehot();
    offer(k, 1'b0, 1'b1);
    tick();
    key_valid = 1'b0;
    exp_count++;
    total++;
    if ({rotate_r, rotate_m, rotate_l} !== 3'b111 || key_count !== exp_count) begin
      bad++; $display("FAIL rst_new_key got=%b cnt=%h want=111 cnt=%h", {rotate_r, rotate_m, rotate_l}, key_count, exp_count);
    end
    for (int c = 1; c <= LAT; c++) begin
      tick();
      total++;
      if (char_valid !== 1'(c == LAT)) begin
        bad++; $display("FAIL rst_new_latency c=%0d got=%b want=%b", c, char_valid, 1'(c == LAT));
      end
    end
    total++;
    if (char_out !== k) begin bad++; $display("FAIL rst_new_char got=%h want=%h", char_out, k); end
    char_ack = 1'b1;
    tick();
    char_ack = 1'b0;
  endtask

  task automatic test_wrap();
    force dut.key_count_q = 16'hFFFF;
    #1;
    release dut.key_count_q;
    exp_count = 16'hFFFF;
    @(negedge clock);
    total++;
    if (key_count !== exp_count) begin bad++; $display("FAIL wrap_preload got=%h want=%h", key_count, exp_count); end
    offer(rand_onehot(), 1'b0, 1'b0);
    tick();
    exp_count++;
    total++;
    if (key_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h want=0000", key_count); end
    complete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [25:0] k;
      logic        nr;
      logic        nm;
      if ($urandom_range(0, 3) != 0) begin
        k = rand_onehot();
      end else if ($urandom_range(0, 2) == 0) begin
        k = 26'd0;
      end else begin
        k = 26'($urandom);
        if ($countones(k) == 1) k = k | ((k == 26'd1) ? 26'd2 : 26'd1);
      end
      nr = 1'($urandom_range(0, 1));
      nm = 1'($urandom_range(0, 1));
      offer(k, nr, nm);
      tick();
      if ($countones(k) == 1) begin
        exp_count++;
        total++;
        if ({rotate_r, rotate_m, rotate_l, key_ready, bad_key} !== {1'b1, nr | nm, nm, 2'b00} || key_count !== exp_count) begin
          bad++; $display("FAIL rnd_accept n=%0d got=%b cnt=%h want=%b cnt=%h", n,
                          {rotate_r, rotate_m, rotate_l, key_ready, bad_key}, key_count,
                          {1'b1, nr | nm, nm, 2'b00}, exp_count);
        end
        for (int c = 1; c <= LAT; c++) begin
          key_valid = 1'($urandom_range(0, 1));
          key_in    = 26'($urandom);
          notch_r   = 1'($urandom_range(0, 1));
          notch_m   = 1'($urandom_range(0, 1));
          char_ack  = 1'($urandom_range(0, 1));
          tick();
          total++;
          if ({rotate_r, rotate_m, rotate_l, key_ready, bad_key, char_valid} !== {5'b00000, 1'(c == LAT)}) begin
            bad++; $display("FAIL rnd_settle n=%0d c=%0d got=%b want=%b", n, c,
                            {rotate_r, rotate_m, rotate_l, key_ready, bad_key, char_valid}, {5'b00000, 1'(c == LAT)});
          end
        end
        repeat ($urandom_range(0, 3)) begin
          char_ack  = 1'b0;
          key_valid = 1'($urandom_range(0, 1));
          key_in    = rand_onehot();
          tick();
        end
        total++;
        if ({char_valid, key_ready} !== 2'b10 || char_out !== k) begin
          bad++; $display("FAIL rnd_present n=%0d got=%b out=%h want=10 out=%h", n, {char_valid, key_ready}, char_out, k);
        end
        char_ack  = 1'b1;
        key_valid = 1'($urandom_range(0, 1));
        key_in    = rand_onehot();
        tick();
        char_ack  = 1'b0;
        key_valid = 1'b0;
        total++;
        if ({char_valid, key_ready} !== 2'b01 || key_count !== exp_count) begin
          bad++; $display("FAIL rnd_done n=%0d got=%b cnt=%h want=01 cnt=%h", n, {char_valid, key_ready}, key_count, exp_count);
        end
      end else begin
        total++;
        if ({bad_key, key_ready, rotate_r, rotate_m, rotate_l} !== 5'b11000 || key_count !== exp_count) begin
          bad++; $display("FAIL rnd_reject n=%0d got=%b cnt=%h want=11000 cnt=%h", n,
                          {bad_key, key_ready, rotate_r, rotate_m, rotate_l}, key_count, exp_count);
        end
        key_valid = 1'b0;
        tick();
        total++;
        if (bad_key !== 1'b0) begin bad++; $display("FAIL rnd_reject_end n=%0d got=%b want=0", n, bad_key); end
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_double_step();
    test_bad_key();
    test_hold();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
